// File: rtl/de0qsys_button_irq.sv
`default_nettype none
// ============================================================================
// Module : de0qsys_button_irq
// Debounced button PIO with per-bit edge capture and masked level IRQ (Avalon-MM).
// Rev    : 1.0
// ============================================================================
module de0qsys_button_irq #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned       c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]        c_addr_stable = 2'd0;
    localparam logic [1:0]        c_addr_raw    = 2'd1;
    localparam logic [1:0]        c_addr_mask   = 2'd2;
    localparam logic [1:0]        c_addr_edge   = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d, stable_dly_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    // Upper write-data bits are architecturally ignored.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_debounce
        logic [c_cnt_w-1:0] cnt_q, cnt_d;
        logic               stable_bit_d;

        always_comb begin
            cnt_d        = '0;
            stable_bit_d = stable_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q == c_cnt_last) begin
                    stable_bit_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stable_d[i] = stable_bit_d;
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = stable_q & ~stable_dly_q;
            1:       edge_det = ~stable_q & stable_dly_q;
            default: edge_det = stable_q ^ stable_dly_q;
        endcase
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        mask_d   = mask_q;
        clr_bits = '0;
        if (wr_en && (address == c_addr_mask)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == c_addr_edge)) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        // A fresh edge wins over a same-cycle clear of that bit.
        edge_cap_d = (edge_cap_q & ~clr_bits) | edge_det;
        irq_d      = |(edge_cap_q & mask_q);

        rdata_d = '0;
        case (address)
            c_addr_stable: rdata_d[WIDTH-1:0] = stable_q;
            c_addr_raw:    rdata_d[WIDTH-1:0] = sync2_q;
            c_addr_mask:   rdata_d[WIDTH-1:0] = mask_q;
            default:       rdata_d[WIDTH-1:0] = edge_cap_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            edge_cap_q   <= '0;
            mask_q       <= IRQ_MASK_RESET;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edge_cap_q   <= edge_cap_d;
            mask_q       <= mask_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_de0qsys_button_irq.sv
`default_nettype none
// ============================================================================
// Module : tb_de0qsys_button_irq
// Self-checking bench: falling-edge instance plus an any-edge instance on a shared bus.
// Rev    : 1.0
// ============================================================================
module tb_de0qsys_button_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs1, cs2, write_n;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd1, rd2;
    logic        irq1, irq2;

    always #5 clk = ~clk;

    de0qsys_button_irq #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IRQ_MASK_RESET(4'h0)
    ) u_dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .irq(irq1)
    );

    de0qsys_button_irq #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IRQ_MASK_RESET(4'h0)
    ) u_dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .irq(irq2)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          sel2;
    } sb_t;

    typedef struct {
        bit          we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read path: expectation is queued when the address is driven, popped when readdata lands.
    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp, input bit sel2);
        sb_t e;
        address = a;
        write_n = 1'b1;
        cs1     = 1'b0;
        cs2     = 1'b0;
        e.name  = nm;
        e.exp   = exp;
        e.sel2  = sel2;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.name, e.sel2 ? rd2 : rd1, e.exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit sel2);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs1       = !sel2;
        cs2       = sel2;
        @(negedge clk);
        write_n = 1'b1;
        cs1     = 1'b0;
        cs2     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cs1 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_port = 4'hF;
        tick(3);
        chk("rst_readdata", rd1, 32'h0);
        chk("rst_irq", irq1, 32'h0);
        chk("rst_irq_any", irq2, 32'h0);
        reset = 1'b0;
        tick(10);

        tbl[0] = '{1'b0, 2'd0, 32'h0,         32'hF, "stable_init"};
        tbl[1] = '{1'b0, 2'd1, 32'h0,         32'hF, "raw_init"};
        tbl[2] = '{1'b0, 2'd2, 32'h0,         32'h0, "mask_reset"};
        tbl[3] = '{1'b0, 2'd3, 32'h0,         32'h0, "cap_no_fall"};
        tbl[4] = '{1'b1, 2'd0, 32'h0,         32'h0, "wr_stable"};
        tbl[5] = '{1'b0, 2'd0, 32'h0,         32'hF, "stable_readonly"};
        tbl[6] = '{1'b1, 2'd2, 32'hFFFF_FFF1, 32'h0, "wr_mask"};
        tbl[7] = '{1'b0, 2'd2, 32'h0,         32'h1, "mask_upper_ignored"};
        tbl[8] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, "wr_w1c"};
        tbl[9] = '{1'b0, 2'd3, 32'h0,         32'h0, "w1c_empty"};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].data, 1'b0);
            else           rd(tbl[i].name, tbl[i].addr, tbl[i].exp, 1'b0);
        end
        chk("irq_idle", irq1, 32'h0);
        rd("any_reset_rise", 2'd3, 32'hF, 1'b1);

        // Three-cycle glitch on bit 0 must be filtered.
        in_port = 4'hE; tick(3); in_port = 4'hF; tick(8);
        rd("glitch_stable", 2'd0, 32'hF, 1'b0);
        rd("glitch_capture", 2'd3, 32'h0, 1'b0);
        chk("glitch_irq", irq1, 32'h0);

        // Held falling edge on bit 0: irq exactly 8 cycles after the input change.
        address = 2'd0; in_port = 4'hE;
        tick(7); chk("irq_not_early", irq1, 32'h0);
        tick(1); chk("irq_fall0", irq1, 32'h1);
        rd("cap_fall0", 2'd3, 32'h1, 1'b0);
        wr(2'd3, 32'h1, 1'b0);
        rd("cap_cleared", 2'd3, 32'h0, 1'b0);
        chk("irq_cleared", irq1, 32'h0);

        // Two captured bits, partial clear, then clear racing a new edge.
        in_port = 4'hF; tick(10);
        in_port = 4'hC; tick(10);
        rd("cap_two", 2'd3, 32'h3, 1'b0);
        wr(2'd3, 32'h1, 1'b0);
        rd("cap_w1c_bit0", 2'd3, 32'h2, 1'b0);
        in_port = 4'hE; tick(10);
        in_port = 4'hC; tick(6);
        wr(2'd3, 32'h2, 1'b0);
        rd("cap_edge_priority", 2'd3, 32'h2, 1'b0);
        chk("irq_masked_bit1", irq1, 32'h0);
        wr(2'd3, 32'h2, 1'b0);
        rd("cap_w1c_bit1", 2'd3, 32'h0, 1'b0);

        // Any-edge instance: both directions on bit 2, mask 0 keeps irq low.
        wr(2'd3, 32'hF, 1'b1);
        rd("any_cleared", 2'd3, 32'h0, 1'b1);
        in_port = 4'h8; tick(10);
        rd("any_fall2", 2'd3, 32'h4, 1'b1);
        wr(2'd3, 32'h4, 1'b1);
        rd("any_fall2_clr", 2'd3, 32'h0, 1'b1);
        in_port = 4'hC; tick(10);
        rd("any_rise2", 2'd3, 32'h4, 1'b1);
        chk("any_irq_masked", irq2, 32'h0);
        rd("fall_only_bit2", 2'd3, 32'h4, 1'b0);

        // Reset in the middle of a debounce on bit 3 (counter at 2).
        wr(2'd2, 32'hF, 1'b0);
        tick(2);
        chk("irq_before_reset", irq1, 32'h1);
        in_port = 4'h4; tick(4);
        reset = 1'b1; tick(1);
        chk("midrst_readdata", rd1, 32'h0);
        chk("midrst_irq", irq1, 32'h0);
        chk("midrst_irq_any", irq2, 32'h0);
        reset = 1'b0;
        rd("midrst_mask", 2'd2, 32'h0, 1'b0);
        rd("midrst_capture", 2'd3, 32'h0, 1'b0);
        tick(10);
        rd("stable_post_reset", 2'd0, 32'h4, 1'b0);
        rd("cap_post_reset", 2'd3, 32'h0, 1'b0);
        rd("any_post_reset", 2'd3, 32'h4, 1'b1);
        chk("irq_post_reset", irq1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
